// File: rtl/snek_game_ctrl_pkg.sv
// Shared types for the snek game sequencer: FSM states, direction codes,
// button bit positions and playfield limits.
package snek_pkg;

   localparam int GRID_W = 32;
   localparam int GRID_H = 24;

   // btn_dir bit positions happen to equal the direction codes
   localparam int BTN_LEFT  = 0;
   localparam int BTN_RIGHT = 1;
   localparam int BTN_DOWN  = 2;
   localparam int BTN_UP    = 3;

   typedef enum logic [1:0] {
      ST_SPLASH = 2'd0,
      ST_CLEAR  = 2'd1,
      ST_RUN    = 2'd2,
      ST_DEAD   = 2'd3
   } state_e;

   typedef enum logic [2:0] {
      DIR_LEFT  = 3'd0,
      DIR_RIGHT = 3'd1,
      DIR_DOWN  = 3'd2,
      DIR_UP    = 3'd3
   } dir_e;

   function automatic dir_e dir_opposite(input dir_e d);
      case (d)
         DIR_LEFT:  return DIR_RIGHT;
         DIR_RIGHT: return DIR_LEFT;
         DIR_DOWN:  return DIR_UP;
         DIR_UP:    return DIR_DOWN;
         default:   return DIR_LEFT;
      endcase
   endfunction

endpackage

// File: rtl/snek_game_ctrl_if.sv
// Signal bundle between the game sequencer and the input/video/snake logic.
interface snek_game_ctrl_if;
   logic       vsync_tick;
   logic       btn_start;
   logic [3:0] btn_dir;
   logic [5:0] head_h;
   logic [5:0] head_v;
   logic       dead;
   logic [5:0] food_h;
   logic [5:0] food_v;
   logic       step;
   logic       run;
   logic       game_rst;
   logic [2:0] dir;
   logic       grow_flag;
   logic       food_req;
   logic [7:0] score;
   logic [1:0] state;

   modport master (
      input  vsync_tick, btn_start, btn_dir, head_h, head_v, dead, food_h, food_v,
      output step, run, game_rst, dir, grow_flag, food_req, score, state
   );

   modport slave (
      output vsync_tick, btn_start, btn_dir, head_h, head_v, dead, food_h, food_v,
      input  step, run, game_rst, dir, grow_flag, food_req, score, state
   );
endinterface

// File: rtl/snek_game_ctrl_dir_filter.sv
// Player direction filter: priority-encodes the buttons (up > down > left > right)
// and rejects a request that would reverse the committed direction.
module snek_dir_filter
   import snek_pkg::*;
(
   input  logic [3:0] btn_dir_i,
   input  dir_e       dir_i,
   output dir_e       pend_dir_o,
   output logic       pend_en_o
);

   logic req_vld;

   always_comb begin
      req_vld    = 1'b1;
      pend_dir_o = DIR_RIGHT;
      if      (btn_dir_i[BTN_UP])    pend_dir_o = DIR_UP;
      else if (btn_dir_i[BTN_DOWN])  pend_dir_o = DIR_DOWN;
      else if (btn_dir_i[BTN_LEFT])  pend_dir_o = DIR_LEFT;
      else if (btn_dir_i[BTN_RIGHT]) pend_dir_o = DIR_RIGHT;
      else                           req_vld    = 1'b0;
   end

   assign pend_en_o = req_vld && (pend_dir_o != dir_opposite(dir_i));

endmodule

// File: rtl/snek_game_ctrl.sv
// Snek game sequencer: SPLASH/CLEAR/RUN/DEAD state machine, movement step
// generation from the frame tick, direction commit, food capture and score.
module snek_game_ctrl
   import snek_pkg::*;
#(
   parameter int MOVE_DIV  = 8,
   parameter int DEAD_HOLD = 120,
   parameter int MAXLEN    = 16
) (
   input logic              clk,
   input logic              rst,
   snek_game_ctrl_if.master ctl_if
);

   localparam int FCNT_W = $clog2(MOVE_DIV);
   localparam int HCNT_W = $clog2(DEAD_HOLD + 1);
   localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(MOVE_DIV - 1);
   localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(DEAD_HOLD - 1);
   localparam logic [7:0]        GROW_LIM  = 8'(MAXLEN - 1);

   state_e            state_q;
   dir_e              dir_q, pend_q, pend_dir;
   logic              pend_en;
   logic [FCNT_W-1:0] fcnt_q;
   logic [HCNT_W-1:0] hcnt_q;
   logic              start_q, sched_q;
   logic [1:0]        eat_pipe_q;
   logic              step_q, run_q, game_rst_q, grow_q, food_req_q;
   logic [7:0]        score_q, score_d;
   logic              start_edge_d, wrap_d, hit_d;

   snek_dir_filter u_dir_filter (
      .btn_dir_i  (ctl_if.btn_dir),
      .dir_i      (dir_q),
      .pend_dir_o (pend_dir),
      .pend_en_o  (pend_en)
   );

   assign start_edge_d = ctl_if.btn_start & ~start_q;
   assign wrap_d       = ctl_if.vsync_tick && (fcnt_q == FCNT_LAST);
   // eat_pipe_q[1] marks the second cycle after a RUN step, when head has moved
   assign hit_d        = eat_pipe_q[1] && (ctl_if.head_h == ctl_if.food_h)
                                       && (ctl_if.head_v == ctl_if.food_v);
   assign score_d      = (score_q == 8'hFF) ? score_q : score_q + 8'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_SPLASH;
         dir_q      <= DIR_RIGHT;
         pend_q     <= DIR_RIGHT;
         fcnt_q     <= '0;
         hcnt_q     <= '0;
         start_q    <= 1'b0;
         sched_q    <= 1'b0;
         eat_pipe_q <= '0;
         step_q     <= 1'b0;
         run_q      <= 1'b0;
         game_rst_q <= 1'b1;
         grow_q     <= 1'b0;
         food_req_q <= 1'b0;
         score_q    <= '0;
      end else begin
         start_q    <= ctl_if.btn_start;
         step_q     <= 1'b0;
         sched_q    <= 1'b0;
         grow_q     <= 1'b0;
         food_req_q <= 1'b0;
         eat_pipe_q <= '0;
         unique case (state_q)
            ST_SPLASH: begin
               step_q <= ctl_if.vsync_tick;
               if (start_edge_d) begin
                  state_q    <= ST_CLEAR;
                  step_q     <= 1'b1;
                  food_req_q <= 1'b1;
                  score_q    <= '0;
                  dir_q      <= DIR_RIGHT;
                  pend_q     <= DIR_RIGHT;
                  fcnt_q     <= '0;
               end
            end
            ST_CLEAR: begin
               state_q    <= ST_RUN;
               run_q      <= 1'b1;
               game_rst_q <= 1'b0;
            end
            ST_RUN: begin
               if (ctl_if.dead) begin
                  state_q <= ST_DEAD;
                  run_q   <= 1'b0;
                  hcnt_q  <= '0;
               end else begin
                  if (pend_en) pend_q <= pend_dir;
                  if (wrap_d) begin
                     fcnt_q  <= '0;
                     dir_q   <= pend_q;
                     sched_q <= 1'b1;
                  end else if (ctl_if.vsync_tick) begin
                     fcnt_q <= fcnt_q + FCNT_W'(1);
                  end
                  step_q     <= sched_q;
                  eat_pipe_q <= {eat_pipe_q[0], step_q};
                  if (hit_d) begin
                     food_req_q <= 1'b1;
                     grow_q     <= (score_q < GROW_LIM);
                     score_q    <= score_d;
                  end
               end
            end
            ST_DEAD: begin
               if (ctl_if.vsync_tick) begin
                  if (hcnt_q == HCNT_LAST) begin
                     state_q    <= ST_SPLASH;
                     game_rst_q <= 1'b1;
                     hcnt_q     <= '0;
                  end else begin
                     hcnt_q <= hcnt_q + HCNT_W'(1);
                  end
               end
            end
         endcase
      end
   end

   assign ctl_if.step      = step_q;
   assign ctl_if.run       = run_q;
   assign ctl_if.game_rst  = game_rst_q;
   assign ctl_if.dir       = dir_q;
   assign ctl_if.grow_flag = grow_q;
   assign ctl_if.food_req  = food_req_q;
   assign ctl_if.score     = score_q;
   assign ctl_if.state     = state_q;

endmodule

// File: tb/tb_snek_game_ctrl.sv
// Bench for snek_game_ctrl: event-timeline reference model compared every
// cycle, plus directed literal checks around start, direction, eat and death.
module tb_snek_game_ctrl;
   localparam int MD = 8;
   localparam int DH = 120;
   localparam int ML = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   snek_game_ctrl_if bus();

   snek_game_ctrl #(.MOVE_DIV(MD), .DEAD_HOLD(DH), .MAXLEN(ML)) dut (
      .clk    (clk),
      .rst    (rst),
      .ctl_if (bus)
   );

   int total = 0;
   int bad = 0;
   int grow_seen = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: expected outputs for the current cycle plus a timeline
   // of scheduled step and eat-check cycles.
   int e_st = 0, e_dir = 1, e_score = 0;
   bit e_step = 0, e_grow = 0, e_food = 0;
   int m_pend = 1, m_ticks = 0, m_hold = 0, mcyc = 0;
   bit m_prev_start = 0;
   int step_due[$];
   int eat_due[$];

   function automatic int pick_dir(input logic [3:0] b);
      int order[4];
      order = '{3, 2, 0, 1};
      foreach (order[i]) if (b[order[i]]) return order[i];
      return -1;
   endfunction

   task automatic model_reset();
      e_st = 0; e_dir = 1; e_score = 0; e_step = 0; e_grow = 0; e_food = 0;
      m_pend = 1; m_ticks = 0; m_hold = 0; m_prev_start = 0;
      step_due.delete(); eat_due.delete();
   endtask

   task automatic model_cycle();
      int n_st, n_dir, req;
      bit n_step, n_grow, n_food;
      n_st = e_st; n_dir = e_dir; n_step = 0; n_grow = 0; n_food = 0;
      case (e_st)
         0: begin
            n_step = bus.vsync_tick;
            if (bus.btn_start && !m_prev_start) begin
               n_st = 1; n_step = 1; n_food = 1; e_score = 0; n_dir = 1;
               m_pend = 1; m_ticks = 0; step_due.delete(); eat_due.delete();
            end
         end
         1: n_st = 2;
         2: begin
            if (bus.dead) begin
               n_st = 3; m_hold = 0; step_due.delete(); eat_due.delete();
            end else begin
               if (eat_due.size() > 0 && eat_due[0] == mcyc) begin
                  void'(eat_due.pop_front());
                  if (bus.head_h == bus.food_h && bus.head_v == bus.food_v) begin
                     n_food = 1;
                     n_grow = (e_score < ML - 1);
                     if (e_score < 255) e_score++;
                  end
               end
               if (step_due.size() > 0 && step_due[0] == mcyc + 1) begin
                  void'(step_due.pop_front());
                  n_step = 1;
                  eat_due.push_back(mcyc + 3);
               end
               if (bus.vsync_tick) begin
                  m_ticks++;
                  if (m_ticks % MD == 0) begin
                     n_dir = m_pend;
                     step_due.push_back(mcyc + 2);
                  end
               end
               req = pick_dir(bus.btn_dir);
               if (req >= 0 && req != (e_dir ^ 1)) m_pend = req;
            end
         end
         default: begin
            if (bus.vsync_tick) begin
               m_hold++;
               if (m_hold == DH) n_st = 0;
            end
         end
      endcase
      m_prev_start = bus.btn_start;
      e_st = n_st; e_dir = n_dir; e_step = n_step; e_grow = n_grow; e_food = n_food;
      mcyc++;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) model_reset();
      else model_cycle();
   end

   always @(negedge clk) begin
      chk("state", bus.state, e_st);
      chk("run", bus.run, e_st == 2);
      chk("game_rst", bus.game_rst, e_st < 2);
      chk("step", bus.step, e_step);
      chk("grow_flag", bus.grow_flag, e_grow);
      chk("food_req", bus.food_req, e_food);
      chk("score", bus.score, e_score);
      if (e_st == 1 || e_st == 2) chk("dir", bus.dir, e_dir);
      if (bus.grow_flag) grow_seen++;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tick_gap(input int gap);
      bus.vsync_tick = 1'b1;
      cyc(1);
      bus.vsync_tick = 1'b0;
      cyc(gap);
   endtask

   task automatic do_step();
      repeat (MD) tick_gap(3);
      cyc(4);
   endtask

   initial begin
      bus.vsync_tick = 0; bus.btn_start = 0; bus.btn_dir = 0;
      bus.head_h = 0; bus.head_v = 0; bus.dead = 0;
      bus.food_h = 6'd5; bus.food_v = 6'd5;
      cyc(3);
      chk("rst_state", bus.state, 0);
      chk("rst_dir", bus.dir, 1);
      chk("rst_game_rst", bus.game_rst, 1);
      chk("rst_score", bus.score, 0);
      chk("rst_step", bus.step, 0);
      rst = 1'b0;
      cyc(2);

      bus.btn_start = 1'b1;
      cyc(1);
      chk("clr_state", bus.state, 1);
      chk("clr_step", bus.step, 1);
      chk("clr_game_rst", bus.game_rst, 1);
      chk("clr_food_req", bus.food_req, 1);
      chk("clr_dir", bus.dir, 1);
      cyc(1);
      chk("run_state", bus.state, 2);
      chk("run_run", bus.run, 1);
      bus.btn_start = 1'b0;

      bus.btn_dir = 4'b0001;
      cyc(1);
      bus.btn_dir = 4'b0000;
      do_step();
      chk("dir_reverse_ignored", bus.dir, 1);
      bus.btn_dir = 4'b1001;
      cyc(1);
      bus.btn_dir = 4'b0000;
      do_step();
      chk("dir_up_priority", bus.dir, 3);

      bus.head_h = 6'd5; bus.head_v = 6'd5;
      do_step();
      chk("eat1_score", bus.score, 1);
      chk("eat1_grows", grow_seen, 1);
      repeat (16) do_step();
      chk("eat17_score", bus.score, 17);
      chk("eat17_grows", grow_seen, 15);

      // death lands on the eat-compare cycle of a food hit
      repeat (MD - 1) tick_gap(3);
      tick_gap(3);
      bus.dead = 1'b1;
      cyc(1);
      chk("death_state", bus.state, 3);
      chk("death_score", bus.score, 17);
      chk("death_grow", bus.grow_flag, 0);
      bus.dead = 1'b0;
      bus.btn_start = 1'b1;
      repeat (DH - 1) tick_gap(1);
      chk("dead_hold", bus.state, 3);
      tick_gap(1);
      chk("dead_to_splash", bus.state, 0);
      cyc(10);
      chk("held_start_ignored", bus.state, 0);
      bus.btn_start = 1'b0;
      cyc(2);
      bus.btn_start = 1'b1;
      cyc(1);
      chk("restart", bus.state, 1);
      bus.btn_start = 1'b0;
      cyc(1);

      for (int i = 0; i < 4000; i++) begin
         bus.vsync_tick = ($urandom_range(0, 2) == 0);
         bus.btn_dir = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
         if ($urandom_range(0, 1) == 1) begin
            bus.head_h = bus.food_h; bus.head_v = bus.food_v;
         end else begin
            bus.head_h = 6'($urandom_range(0, 31)); bus.head_v = 6'($urandom_range(0, 23));
         end
         if ($urandom_range(0, 199) == 0) begin
            bus.food_h = 6'($urandom_range(0, 31)); bus.food_v = 6'($urandom_range(0, 23));
         end
         bus.dead = ($urandom_range(0, 399) == 0);
         if ($urandom_range(0, 29) == 0) bus.btn_start = ~bus.btn_start;
         cyc(1);
      end

      bus.dead = 1'b0; bus.btn_start = 1'b0; bus.btn_dir = 4'b0000;
      repeat (150) tick_gap(1);
      bus.btn_start = 1'b1;
      cyc(1);
      bus.btn_start = 1'b0;
      cyc(1);
      chk("pre_rst_state", bus.state, 2);
      cyc(3);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_state", bus.state, 0);
      chk("arst_run", bus.run, 0);
      chk("arst_game_rst", bus.game_rst, 1);
      chk("arst_dir", bus.dir, 1);
      chk("arst_step", bus.step, 0);
      chk("arst_score", bus.score, 0);
      chk("arst_food_req", bus.food_req, 0);
      cyc(2);
      rst = 1'b0;
      cyc(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
